// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched RV32I ALU ops,
// wakes operands from the CDB and issues the oldest ready op.
module alu_reservation_station #(
  parameter int ROB_ADDR_WIDTH = 4,
  parameter int RS_DEPTH       = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      dispatch_valid,
  input  logic [3:0]                dispatch_alu_op,
  input  logic [31:0]               dispatch_src1_value,
  input  logic                      dispatch_src1_ready,
  input  logic [ROB_ADDR_WIDTH-1:0] dispatch_src1_tag,
  input  logic [31:0]               dispatch_src2_value,
  input  logic                      dispatch_src2_ready,
  input  logic [ROB_ADDR_WIDTH-1:0] dispatch_src2_tag,
  input  logic [ROB_ADDR_WIDTH-1:0] dispatch_dest_tag,
  output logic                      rs_full,
  output logic [$clog2(RS_DEPTH):0] rs_count,
  input  logic                      cdb_valid,
  input  logic [ROB_ADDR_WIDTH-1:0] cdb_tag,
  input  logic [31:0]               cdb_value,
  output logic                      issue_valid,
  input  logic                      issue_ready,
  output logic [3:0]                issue_alu_op,
  output logic [31:0]               issue_src1_value,
  output logic [31:0]               issue_src2_value,
  output logic [ROB_ADDR_WIDTH-1:0] issue_dest_tag
);

  localparam int IW = $clog2(RS_DEPTH);
  localparam int CW = IW + 1;
  localparam int TW = ROB_ADDR_WIDTH;

  typedef struct packed {
    logic [3:0]    op;
    logic [31:0]   v1;
    logic          r1;
    logic [TW-1:0] t1;
    logic [31:0]   v2;
    logic          r2;
    logic [TW-1:0] t2;
    logic [TW-1:0] dest;
  } rs_entry_t;

  rs_entry_t           ent_q [RS_DEPTH];
  logic [RS_DEPTH-1:0] vld_q;
  // older_q[i][j] set means entry j was dispatched before entry i
  logic [RS_DEPTH-1:0] older_q [RS_DEPTH];
  logic [CW-1:0]       count_q;

  logic [RS_DEPTH-1:0] elig;
  logic [IW-1:0]       sel;
  logic [IW-1:0]       free_idx;
  logic                accept;
  logic                fire;
  rs_entry_t           new_ent;

  assign rs_count = count_q;
  assign rs_full  = (count_q == CW'(RS_DEPTH));
  assign accept   = dispatch_valid & ~rs_full;
  assign issue_valid = |elig;
  assign fire     = issue_valid & issue_ready;

  // Oldest eligible entry: eligible with no older eligible entry
  always_comb begin
    elig = '0;
    sel  = '0;
    for (int i = 0; i < RS_DEPTH; i++)
      elig[i] = vld_q[i] & ent_q[i].r1 & ent_q[i].r2;
    for (int i = 0; i < RS_DEPTH; i++)
      if (elig[i] && !(|(elig & older_q[i])))
        sel = IW'(i);
  end

  // Lowest-index free slot for an incoming dispatch
  always_comb begin
    free_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--)
      if (!vld_q[i])
        free_idx = IW'(i);
  end

  // Incoming entry, including same-cycle CDB bypass per source
  always_comb begin
    new_ent      = '0;
    new_ent.op   = dispatch_alu_op;
    new_ent.t1   = dispatch_src1_tag;
    new_ent.t2   = dispatch_src2_tag;
    new_ent.dest = dispatch_dest_tag;
    new_ent.v1   = dispatch_src1_value;
    new_ent.r1   = dispatch_src1_ready;
    new_ent.v2   = dispatch_src2_value;
    new_ent.r2   = dispatch_src2_ready;
    if (!dispatch_src1_ready && cdb_valid &&
        cdb_tag == dispatch_src1_tag) begin
      new_ent.v1 = cdb_value;
      new_ent.r1 = 1'b1;
    end
    if (!dispatch_src2_ready && cdb_valid &&
        cdb_tag == dispatch_src2_tag) begin
      new_ent.v2 = cdb_value;
      new_ent.r2 = 1'b1;
    end
  end

  // Issue outputs follow the selected entry, zero when idle
  always_comb begin
    issue_alu_op     = '0;
    issue_src1_value = '0;
    issue_src2_value = '0;
    issue_dest_tag   = '0;
    if (issue_valid) begin
      issue_alu_op     = ent_q[sel].op;
      issue_src1_value = ent_q[sel].v1;
      issue_src2_value = ent_q[sel].v2;
      issue_dest_tag   = ent_q[sel].dest;
    end
  end

  // Entry state: reset/flush clear, wakeup, issue free, dispatch
  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        ent_q[i]   <= '0;
        older_q[i] <= '0;
      end
    end else if (flush) begin
      vld_q   <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (vld_q[i] && cdb_valid) begin
          if (!ent_q[i].r1 && ent_q[i].t1 == cdb_tag) begin
            ent_q[i].v1 <= cdb_value;
            ent_q[i].r1 <= 1'b1;
          end
          if (!ent_q[i].r2 && ent_q[i].t2 == cdb_tag) begin
            ent_q[i].v2 <= cdb_value;
            ent_q[i].r2 <= 1'b1;
          end
        end
      end
      if (fire)
        vld_q[sel] <= 1'b0;
      if (accept) begin
        vld_q[free_idx] <= 1'b1;
        ent_q[free_idx] <= new_ent;
        for (int i = 0; i < RS_DEPTH; i++) begin
          older_q[free_idx][i] <= (IW'(i) != free_idx);
          if (IW'(i) != free_idx)
            older_q[i][free_idx] <= 1'b0;
        end
      end
      count_q <= count_q + CW'(accept) - CW'(fire);
    end
  end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
Receiver for the decode-to-RS dispatch interface. Buffers up to RS_DEPTH dispatched RV32I ALU ops and snoops the common data bus (CDB) to wake waiting operands. Issues the oldest fully-ready op to the ALU over a valid/ready handshake. Drives rs_full back to decode.

Parameters:
ROB_ADDR_WIDTH, 4, ROB tag width.
RS_DEPTH, 4, number of entries (power of 2, at least 2).

Ports:
clock  input  1  system clock.
reset  input  1  synchronous, active-low reset (0 = reset).
flush  input  1  synchronous clear of all entries (mispredict/exception).
dispatch_valid  input  1  dispatch request from decode.
dispatch_alu_op  input  4  ALU op code (0000 ADD … 1001 AND).
dispatch_src1_value  input  32  src1 value, meaningful when ready.
dispatch_src1_ready  input  1  src1 value valid.
dispatch_src1_tag  input  ROB_ADDR_WIDTH  producer tag when src1 is not ready.
dispatch_src2_value  input  32  src2 value or immediate.
dispatch_src2_ready  input  1  src2 value valid.
dispatch_src2_tag  input  ROB_ADDR_WIDTH  producer tag when src2 is not ready.
dispatch_dest_tag  input  ROB_ADDR_WIDTH  ROB tag of the result.
rs_full  output  1  no free entry; decode must not dispatch.
rs_count  output  $clog2(RS_DEPTH)+1  occupied entries.
cdb_valid  input  1  CDB broadcast valid.
cdb_tag  input  ROB_ADDR_WIDTH  broadcast producer tag.
cdb_value  input  32  broadcast result.
issue_valid  output  1  an op is presented to the ALU.
issue_ready  input  1  ALU accepts the op this cycle.
issue_alu_op  output  4  op code of the issued op.
issue_src1_value  output  32  operand 1.
issue_src2_value  output  32  operand 2.
issue_dest_tag  output  ROB_ADDR_WIDTH  result tag.

Behaviour:
- Entry state: valid, op, src1 {value, ready, tag}, src2 {value, ready, tag}, dest tag, and age ordering. All entry state is registered.
- Reset (reset==0 at posedge):
  - All entries are invalidated.
  - rs_full=0, rs_count=0, issue_valid=0, all issue data outputs = 0.
  - Reset takes priority over flush, dispatch, CDB and issue.
  - Reset mid-operation discards everything.
- Flush at posedge (reset inactive): clears all entries the same as reset. Dispatch, CDB and issue in that cycle are dropped and no handshake completes.
- rs_full = (rs_count == RS_DEPTH). It is derived only from registered state, so there is no combinational path from the dispatch inputs.
- Dispatch:
  - Accepted when dispatch_valid && !rs_full.
  - The op is written into the lowest-index free entry and marked youngest.
  - dispatch_valid while rs_full is ignored, with no state change.
  - Full with a simultaneous issue: the dispatch is still refused; the freed slot is usable from the next cycle.
- Same-cycle bypass: if a dispatched source is not ready, cdb_valid=1 and cdb_tag equals that source's tag, the entry stores cdb_value with ready=1.
- Wakeup:
  - On cdb_valid, every valid entry whose source is not ready and whose tag matches cdb_tag captures cdb_value and sets ready=1.
  - Sources already ready ignore the CDB.
  - Both sources of one entry may wake in the same cycle.
- Select and issue:
  - An entry is eligible when valid and both sources are ready.
  - issue_valid=1 when any entry is eligible. The issue_* outputs combinationally show the oldest eligible entry (dispatch order).
  - When issue_valid && issue_ready, that entry is freed at the posedge. issue_* may change in the same cycle only through reset or flush.
  - When issue_valid=0, all issue data outputs are 0.
  - Latency: an op dispatched ready at posedge N is presented from cycle N+1. An op woken by the CDB in cycle M is presented from cycle M+1.
  - At most one issue per cycle.
- Counting: rs_count changes by +1 for an accepted dispatch and -1 for a completed issue. Both in one cycle gives net 0. The count never wraps.
- Ordering: age is preserved across frees and reuse. A reused low-index slot is still the youngest entry.
- Entries are never issued with an unready source. The dest tag is not compared with the CDB.

Test Plan:
1. Reset and idle: reset=0 for 2 cycles with dispatch_valid=1 → rs_full=0, rs_count=0, issue_valid=0, all issue data 0. Release reset → still idle.
2. Ready-at-dispatch: dispatch op=0000, src1=5 ready, src2=7 ready, dest=3, issue_ready=1 → next cycle issue_valid=1, op=0000, src1=5, src2=7, dest=3. The following cycle issue_valid=0, rs_count=0.
3. CDB wakeup: dispatch src1 not ready with tag=2, src2=10 ready, dest=4 → issue_valid stays 0. Broadcast cdb tag=2, value=0x20 → next cycle issue src1=0x20, src2=10, dest=4.
4. Same-cycle bypass: dispatch src1 not ready with tag=6 while cdb_valid=1, tag=6, value=0x55 → next cycle issue_valid=1, src1=0x55. A later CDB with tag=6 and value=0x99 has no effect.
5. Full and age order:
   - With issue_ready=0, dispatch 4 ready ops with dest 1, 2, 3, 4 → rs_full=1, rs_count=4.
   - A 5th dispatch with dest=5 is ignored.
   - Set issue_ready=1 → dests 1, 2, 3, 4 issue in consecutive cycles. rs_full=0 in the cycle after the first issue.
   - Dest 5 is never issued.
6. Flush: 3 entries held with issue_ready=0; assert flush together with a dispatch of dest=7 → next cycle rs_count=0, rs_full=0, issue_valid=0, and dest=7 is never issued.
